amci_arbiter: RTL and testbench

AMCI_ARBITER -- requirements
Module: amci_arbiter

---
 rtl/amci_arbiter.sv | 112 +++++++++++
 tb/tb_amci_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amci_arbiter.sv
// amci_arbiter: two-requester AMCI arbiter with independent write and read channels.
// Define AMCI_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module amci_arbiter (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic [97:0] AMCI0_MOSI,
    output logic [33:0] AMCI0_MISO,
    input  logic [97:0] AMCI1_MOSI,
    output logic [33:0] AMCI1_MISO,
    output logic [97:0] AMCI_MOSI,
    input  logic [33:0] AMCI_MISO
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t w_st, w_nx, r_st, r_nx;
    logic [97:0] mosi [2];
    logic [1:0] wr_in, rd_in, wpend, rpend, wbusy, rbusy, widle, ridle;
    logic [63:0] w_hold [2];
    logic [31:0] r_hold [2];
    logic [31:0] rdata [2];
    logic [63:0] w_out;
    logic [31:0] r_out;
    logic w_sel, r_sel, r_win, w_go, r_go, w_fin, r_fin;

    assign mosi[0] = AMCI0_MOSI;
    assign mosi[1] = AMCI1_MOSI;
    assign wr_in = {AMCI1_MOSI[96], AMCI0_MOSI[96]};
    assign rd_in = {AMCI1_MOSI[97], AMCI0_MOSI[97]};
    // Idle drops in the same cycle as the request pulse itself.
    assign widle = ~wpend & ~wbusy & ~wr_in;
    assign ridle = ~rpend & ~rbusy & ~rd_in;
    assign AMCI0_MISO = {ridle[0], widle[0], rdata[0]};
    assign AMCI1_MISO = {ridle[1], widle[1], rdata[1]};
    assign AMCI_MOSI = {r_st == ISSUE, w_st == ISSUE, r_out, w_out};

`ifdef AMCI_ARB_FIXED_PRIO_EN
    assign w_sel = ~wpend[0];
    assign r_sel = ~rpend[0];
`else
    logic w_lg, r_lg;
    // On a tie the requester not granted last on that channel wins.
    assign w_sel = &wpend ? ~w_lg : wpend[1];
    assign r_sel = &rpend ? ~r_lg : rpend[1];
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
        if (!M_AXI_ARESETN) begin
            w_lg <= 1'b1;
            r_lg <= 1'b1;
        end else begin
            if (w_go) w_lg <= w_sel;
            if (r_go) r_lg <= r_sel;
        end
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
        if (!M_AXI_ARESETN) begin
            w_st <= IDLE;
            r_st <= IDLE;
        end else begin
            w_st <= w_nx;
            r_st <= r_nx;
        end

    always_comb begin
        w_nx = w_st == IDLE ? (|wpend ? ISSUE : IDLE) : w_st == ISSUE ? WAIT : (AMCI_MISO[32] ? IDLE : WAIT);
        r_nx = r_st == IDLE ? (|rpend ? ISSUE : IDLE) : r_st == ISSUE ? WAIT : (AMCI_MISO[33] ? IDLE : WAIT);
    end

    always_comb begin
        w_go = w_st == IDLE && |wpend;
        r_go = r_st == IDLE && |rpend;
        w_fin = w_st == WAIT && AMCI_MISO[32];
        r_fin = r_st == WAIT && AMCI_MISO[33];
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
        if (!M_AXI_ARESETN) begin
            wpend <= '0;
            rpend <= '0;
            wbusy <= '0;
            rbusy <= '0;
            r_win <= 1'b0;
            w_out <= '0;
            r_out <= '0;
            for (int i = 0; i < 2; i++) begin
                w_hold[i] <= '0;
                r_hold[i] <= '0;
                rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_in[i] && !wpend[i] && !wbusy[i]) begin
                    wpend[i] <= 1'b1;
                    w_hold[i] <= mosi[i][63:0];
                end
                if (rd_in[i] && !rpend[i] && !rbusy[i]) begin
                    rpend[i] <= 1'b1;
                    r_hold[i] <= mosi[i][95:64];
                end
            end
            if (w_go) begin
                wpend[w_sel] <= 1'b0;
                w_out <= w_hold[w_sel];
            end
            if (r_go) begin
                rpend[r_sel] <= 1'b0;
                r_out <= r_hold[r_sel];
                r_win <= r_sel;
            end
            wbusy <= w_go ? (w_sel ? 2'b10 : 2'b01) : w_fin ? 2'b00 : wbusy;
            rbusy <= r_go ? (r_sel ? 2'b10 : 2'b01) : r_fin ? 2'b00 : rbusy;
            if (r_fin) rdata[r_win] <= AMCI_MISO[31:0];
        end
endmodule

// File: tb/tb_amci_arbiter.sv
// tb_amci_arbiter: directed and random checks of amci_arbiter against a transaction-level model.
module tb_amci_arbiter;
    logic        M_AXI_ACLK = 1'b0;
    logic        M_AXI_ARESETN = 1'b0;
    logic [97:0] AMCI0_MOSI = '0;
    logic [97:0] AMCI1_MOSI = '0;
    logic [33:0] AMCI0_MISO, AMCI1_MISO, AMCI_MISO;
    logic [97:0] AMCI_MOSI;
    int ds_wcnt = 0, ds_rcnt = 0;
    int wlat = 2, rlat = 2;
    bit rnd_lat = 0;
    int n_assert = 0, n_fail = 0;
    logic [1:0] pw = '0, pr = '0;
    logic [31:0] wa [2], wd [2], ra [2];
    logic [31:0] w_log [$], r_log [$];
    bit m_pend [2][2];
    logic [63:0] m_pay [2][2];
    int m_own [2];
    bit m_pulse [2];
    logic [63:0] m_out [2];
    int m_lg [2];
    logic [31:0] m_rdata [2];

    amci_arbiter dut (
        .M_AXI_ACLK(M_AXI_ACLK),
        .M_AXI_ARESETN(M_AXI_ARESETN),
        .AMCI0_MOSI(AMCI0_MOSI),
        .AMCI0_MISO(AMCI0_MISO),
        .AMCI1_MOSI(AMCI1_MOSI),
        .AMCI1_MISO(AMCI1_MISO),
        .AMCI_MOSI(AMCI_MOSI),
        .AMCI_MISO(AMCI_MISO)
    );

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return a == 32'h2000 ? 32'h1234_5678 : (a ^ 32'hA5A5_0000) + 32'd3;
    endfunction

    // Downstream AXI4-Lite master stand-in: busy for a programmable number of cycles per pulse.
    assign AMCI_MISO = {ds_rcnt == 0 && !AMCI_MOSI[97], ds_wcnt == 0 && !AMCI_MOSI[96], mem_rd(AMCI_MOSI[95:64])};

    function automatic logic [31:0] qat(input logic [31:0] q [$], input int i);
        return i < q.size() ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        AMCI0_MOSI = {pr[0], pw[0], ra[0], wd[0], wa[0]};
        AMCI1_MOSI = {pr[1], pw[1], ra[1], wd[1], wa[1]};
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int n = 0; n < 2; n++) begin
                m_pend[c][n] = 0;
                m_pay[c][n] = '0;
            end
            m_own[c] = -1;
            m_pulse[c] = 0;
            m_out[c] = '0;
            m_lg[c] = 1;
            m_rdata[c] = '0;
        end
        ds_wcnt = 0;
        ds_rcnt = 0;
    endtask

    // One clock of the arbitration rules: accept, grant, one-cycle pulse, wait for downstream idle.
    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            logic [1:0] p;
            bit ds_idle;
            bit np [2];
            int win;
            p = c == 0 ? pw : pr;
            ds_idle = (c == 0 ? ds_wcnt : ds_rcnt) == 0 && !m_pulse[c];
            for (int n = 0; n < 2; n++) np[n] = m_pend[c][n];
            for (int n = 0; n < 2; n++)
                if (p[n] && !m_pend[c][n] && m_own[c] != n) begin
                    np[n] = 1;
                    m_pay[c][n] = c == 0 ? {wd[n], wa[n]} : {32'h0, ra[n]};
                end
            if (m_own[c] < 0) begin
                if (m_pend[c][0] || m_pend[c][1]) begin
`ifdef AMCI_ARB_FIXED_PRIO_EN
                    win = m_pend[c][0] ? 0 : 1;
`else
                    win = (m_pend[c][0] && m_pend[c][1]) ? 1 - m_lg[c] : (m_pend[c][0] ? 0 : 1);
`endif
                    m_lg[c] = win;
                    m_own[c] = win;
                    m_pulse[c] = 1;
                    np[win] = 0;
                    m_out[c] = m_pay[c][win];
                end
            end else if (m_pulse[c]) begin
                m_pulse[c] = 0;
            end else if (ds_idle) begin
                if (c == 1) m_rdata[m_own[c]] = mem_rd(m_out[1][31:0]);
                m_own[c] = -1;
            end
            for (int n = 0; n < 2; n++) m_pend[c][n] = np[n];
        end
    endtask

    // Entered at a falling edge: apply requests, check against model, advance one clock.
    task automatic cyc();
        int nw, nr;
        logic [33:0] mi [2];
        drive();
        #1;
        mi[0] = AMCI0_MISO;
        mi[1] = AMCI1_MISO;
        chk("ds_write", AMCI_MOSI[96], m_pulse[0]);
        chk("ds_read", AMCI_MOSI[97], m_pulse[1]);
        chk("ds_wpayload", AMCI_MOSI[63:0], m_out[0]);
        chk("ds_raddr", AMCI_MOSI[95:64], m_out[1][31:0]);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("widle%0d", n), mi[n][32], !m_pend[0][n] && m_own[0] != n && !pw[n]);
            chk($sformatf("ridle%0d", n), mi[n][33], !m_pend[1][n] && m_own[1] != n && !pr[n]);
            chk($sformatf("rdata%0d", n), mi[n][31:0], m_rdata[n]);
        end
        if (AMCI_MOSI[96]) w_log.push_back(AMCI_MOSI[31:0]);
        if (AMCI_MOSI[97]) r_log.push_back(AMCI_MOSI[95:64]);
        nw = AMCI_MOSI[96] ? (rnd_lat ? int'($urandom_range(0, 3)) : wlat) : (ds_wcnt > 0 ? ds_wcnt - 1 : 0);
        nr = AMCI_MOSI[97] ? (rnd_lat ? int'($urandom_range(0, 3)) : rlat) : (ds_rcnt > 0 ? ds_rcnt - 1 : 0);
        if (M_AXI_ARESETN) model_step();
        @(posedge M_AXI_ACLK);
        #1;
        if (M_AXI_ARESETN) begin
            ds_wcnt = nw;
            ds_rcnt = nr;
        end
        pw = '0;
        pr = '0;
        drive();
        @(negedge M_AXI_ACLK);
    endtask

    task automatic do_reset();
        M_AXI_ARESETN = 1'b0;
        model_reset();
        w_log.delete();
        r_log.delete();
        repeat (2) cyc();
        M_AXI_ARESETN = 1'b1;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            wa[n] = '0;
            wd[n] = '0;
            ra[n] = '0;
        end
        model_reset();
        @(negedge M_AXI_ACLK);
        chk("rst_mosi", AMCI_MOSI, '0);
        chk("rst_miso0", AMCI0_MISO, 34'h3_0000_0000);
        chk("rst_miso1", AMCI1_MISO, 34'h3_0000_0000);
        repeat (2) cyc();
        M_AXI_ARESETN = 1'b1;
        repeat (2) cyc();
        chk("idle_miso0", AMCI0_MISO, 34'h3_0000_0000);
        chk("idle_miso1", AMCI1_MISO, 34'h3_0000_0000);

        wa[0] = 32'h1000;
        wd[0] = 32'hDEAD_BEEF;
        pw = 2'b01;
        cyc();
        chk("single_pend_widle0", AMCI0_MISO[32], 1'b0);
        chk("single_no_early_pulse", AMCI_MOSI[96], 1'b0);
        cyc();
        chk("single_pulse", AMCI_MOSI[96], 1'b1);
        chk("single_payload", AMCI_MOSI[63:0], 64'hDEAD_BEEF_0000_1000);
        repeat (8) cyc();
        chk("single_count", w_log.size(), 1);
        chk("single_widle0_back", AMCI0_MISO[32], 1'b1);

        do_reset();
        wa[0] = 32'h1100;
        wa[1] = 32'h1200;
        wd[0] = 32'hA0A0_0001;
        wd[1] = 32'hB0B0_0002;
        pw = 2'b11;
        cyc();
        repeat (16) cyc();
        chk("pair1_count", w_log.size(), 2);
        chk("pair1_first", qat(w_log, 0), 32'h1100);
        chk("pair1_second", qat(w_log, 1), 32'h1200);
        wa[0] = 32'h1300;
        pw = 2'b01;
        cyc();
        repeat (8) cyc();
        w_log.delete();
        wa[0] = 32'h1400;
        wa[1] = 32'h1500;
        pw = 2'b11;
        cyc();
        repeat (16) cyc();
        chk("pair2_count", w_log.size(), 2);
`ifdef AMCI_ARB_FIXED_PRIO_EN
        chk("pair2_first", qat(w_log, 0), 32'h1400);
        chk("pair2_second", qat(w_log, 1), 32'h1500);
`else
        chk("pair2_first", qat(w_log, 0), 32'h1500);
        chk("pair2_second", qat(w_log, 1), 32'h1400);
`endif

        w_log.delete();
        r_log.delete();
        ra[0] = 32'h2000;
        pr = 2'b01;
        wa[1] = 32'h3000;
        wd[1] = 32'hCAFE_0001;
        pw = 2'b10;
        cyc();
        cyc();
        chk("conc_both_pulses", AMCI_MOSI[97:96], 2'b11);
        chk("conc_raddr", AMCI_MOSI[95:64], 32'h2000);
        chk("conc_waddr", AMCI_MOSI[31:0], 32'h3000);
        repeat (8) cyc();
        chk("conc_rdata0", AMCI0_MISO[31:0], 32'h1234_5678);
        chk("conc_rdata1", AMCI1_MISO[31:0], 32'h0);

        w_log.delete();
        wlat = 4;
        wa[1] = 32'h4000;
        pw = 2'b10;
        cyc();
        wa[1] = 32'h4444;
        pw = 2'b10;
        cyc();
        cyc();
        wa[1] = 32'h4888;
        pw = 2'b10;
        cyc();
        repeat (12) cyc();
        chk("drop_count", w_log.size(), 1);
        chk("drop_addr", qat(w_log, 0), 32'h4000);
        wlat = 2;

        r_log.delete();
        rlat = 6;
        ra[0] = 32'h5000;
        pr = 2'b01;
        cyc();
        cyc();
        cyc();
        chk("wait_ridle0", AMCI0_MISO[33], 1'b0);
        M_AXI_ARESETN = 1'b0;
        #1;
        chk("rst_async_mosi", AMCI_MOSI, '0);
        model_reset();
        w_log.delete();
        r_log.delete();
        repeat (2) cyc();
        M_AXI_ARESETN = 1'b1;
        repeat (10) cyc();
        chk("rst_no_read", r_log.size(), 0);
        chk("rst_no_write", w_log.size(), 0);
        chk("rst_after_miso0", AMCI0_MISO, 34'h3_0000_0000);
        chk("rst_after_miso1", AMCI1_MISO, 34'h3_0000_0000);
        rlat = 2;

        rnd_lat = 1;
        repeat (400) begin
            for (int n = 0; n < 2; n++) begin
                wa[n] = $urandom;
                wd[n] = $urandom;
                ra[n] = $urandom;
            end
            pw = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
            pr = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
            cyc();
        end
        rnd_lat = 0;
        repeat (12) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
